// File: rtl/modular_mult_check.sv
// rtl/modular_mult_check.sv - bit-serial (a*b) mod base with "result == 1" flag
//
// Computes (a*b) mod base using MSB-first double-and-add. The doubling and the
// addition are each followed by one conditional subtraction of base. Typical use
// is confirming a*a^-1 == 1 (mod base) on the RSA key path. It also serves as a
// general modular multiplier.
//
// Ports:
//   clk_in     system clock, rising edge
//   rst_in     asynchronous active-low reset
//   a_in       multiplicand, must be < base
//   b_in       multiplier, must be < base
//   base       modulus, must be >= 2
//   valid_in   start strobe, sampled only while idle
//   prod_out   (a*b) mod base, held until the next result (0 after an error)
//   match_out  prod_out == 1, qualified by valid_out
//   valid_out  one-cycle result pulse
//   busy_out   high while a job is in flight
//   error_out  illegal operands, qualified by valid_out
module modular_mult_check #(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] base,
  input  logic             valid_in,
  output logic [WIDTH-1:0] prod_out,
  output logic             match_out,
  output logic             valid_out,
  output logic             busy_out,
  output logic             error_out
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ITER,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [IDX_W-1:0] i_q, i_d;

  logic [WIDTH-1:0] prod_q, prod_d;
  logic             match_q, match_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;

  // One WIDTH+1-bit step of the double-and-add recurrence. Because r < base
  // and a < base, each intermediate value is below 2*base. One conditional
  // subtraction therefore restores the r < base invariant after both halves.
  logic [WIDTH:0] base_x;
  logic [WIDTH:0] dbl;
  logic [WIDTH:0] dbl_red;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sum_red;
  logic           operands_bad;

  always_comb begin
    base_x  = {1'b0, base_q};
    dbl     = {r_q, 1'b0};
    dbl_red = (dbl >= base_x) ? (dbl - base_x) : dbl;
    sum     = dbl_red + (b_q[i_q] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    sum_red = (sum >= base_x) ? (sum - base_x) : sum;
  end

  // A modulus of 0 or 1 has no meaningful residue class with a unit.
  // Operands must already be reduced so the recurrence invariant holds.
  assign operands_bad = (base_q < WIDTH'(2)) || (a_q >= base_q) || (b_q >= base_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    base_d  = base_q;
    r_d     = r_q;
    i_d     = i_q;
    prod_d  = prod_q;
    match_d = match_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          a_d     = a_in;
          b_d     = b_in;
          base_d  = base;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (operands_bad) begin
          prod_d  = '0;
          match_d = 1'b0;
          valid_d = 1'b1;
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          r_d     = '0;
          i_d     = IDX_W'(WIDTH - 1);
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        r_d = sum_red[WIDTH-1:0];
        if (i_q == '0) begin
          prod_d  = sum_red[WIDTH-1:0];
          match_d = (sum_red == (WIDTH+1)'(1));
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          i_d = i_q - IDX_W'(1);
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: they reflect the state being entered.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      base_q  <= '0;
      r_q     <= '0;
      i_q     <= '0;
      prod_q  <= '0;
      match_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      base_q  <= base_d;
      r_q     <= r_d;
      i_q     <= i_d;
      prod_q  <= prod_d;
      match_q <= match_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign prod_out  = prod_q;
  assign match_out = match_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
  assign error_out = error_q;

endmodule

// File: tb/tb_modular_mult_check.sv
// tb/tb_modular_mult_check.sv - scoreboard bench for modular_mult_check
module tb_modular_mult_check;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // 8-bit instance
  logic [7:0] a8 = '0, b8 = '0, m8 = '0, p8;
  logic       v8 = 1'b0, mt8, vo8, bz8, er8;

  // 512-bit instance
  logic [511:0] a512 = '0, b512 = '0, m512 = '0, p512;
  logic         v512 = 1'b0, mt512, vo512, bz512, er512;

  modular_mult_check #(.WIDTH(8)) dut8 (
    .clk_in(clk), .rst_in(rst_n), .a_in(a8), .b_in(b8), .base(m8),
    .valid_in(v8), .prod_out(p8), .match_out(mt8), .valid_out(vo8),
    .busy_out(bz8), .error_out(er8)
  );

  modular_mult_check #(.WIDTH(512)) dut512 (
    .clk_in(clk), .rst_in(rst_n), .a_in(a512), .b_in(b512), .base(m512),
    .valid_in(v512), .prod_out(p512), .match_out(mt512), .valid_out(vo512),
    .busy_out(bz512), .error_out(er512)
  );

  typedef struct {
    logic [511:0] prod;
    logic         match;
    logic         err;
    int           due;
  } exp_t;

  exp_t q8[$];
  exp_t q512[$];
  exp_t e8, e512;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitors: pop one expectation per valid_out pulse.
  always @(negedge clk) begin
    if (vo8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid8: valid_out=1 at cycle %0d with no job expected", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("prod8",    512'(p8),  e8.prod);
        chk("match8",   512'(mt8), 512'(e8.match));
        chk("error8",   512'(er8), 512'(e8.err));
        chk("latency8", 512'(cyc), 512'(e8.due));
      end
    end
  end

  always @(negedge clk) begin
    if (vo512 === 1'b1) begin
      if (q512.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid512: valid_out=1 at cycle %0d with no job expected", cyc);
      end else begin
        e512 = q512.pop_front();
        chk("prod512",    p512,        e512.prod);
        chk("match512",   512'(mt512), 512'(e512.match));
        chk("error512",   512'(er512), 512'(e512.err));
        chk("latency512", 512'(cyc),   512'(e512.due));
      end
    end
  end

  // Accept happens on the posedge after this negedge (edge 0 = cyc c+1).
  // Result is visible at the negedge where cyc = c+WIDTH+2 (legal) or c+2 (error).
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        input logic [7:0] ep, input logic em, input logic ee,
                        input bit push, output int c);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; v8 = 1'b1;
    c = cyc;
    e.prod  = 512'(ep);
    e.match = em;
    e.err   = ee;
    e.due   = ee ? c + 2 : c + 10;
    if (push) q8.push_back(e);
    @(negedge clk);
    v8 = 1'b0;
    a8 = '0; b8 = '0; m8 = '0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 2000 && (q8.size() != 0 || q512.size() != 0); k++) @(negedge clk);
    chk(nm, 512'(q8.size() + q512.size()), 512'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int nbusy;
    logic [511:0] a_raw, b_raw, m_raw;
    exp_t e;

    repeat (3) @(negedge clk);
    chk("rst_prod8",  512'(p8),   '0);
    chk("rst_valid8", 512'(vo8),  '0);
    chk("rst_busy8",  512'(bz8),  '0);
    chk("rst_match8", 512'(mt8),  '0);
    chk("rst_err8",   512'(er8),  '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy8",   512'(bz8),   '0);
    chk("idle_busy512", 512'(bz512), '0);
    chk("idle_prod512", p512,        '0);

    // Small legal inverse: 5*8 = 40 = 3*13 + 1
    issue8(8'd5, 8'd8, 8'd13, 8'd1, 1'b1, 1'b0, 1'b1, c);
    nbusy = bz8 ? 1 : 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bz8) nbusy++;
    end
    chk("busy_cycles8", 512'(nbusy), 512'(10));
    drain("drain_inverse8");

    // Non-inverse: 200*150 = 30000 = 119*251 + 131
    issue8(8'd200, 8'd150, 8'd251, 8'd131, 1'b0, 1'b0, 1'b1, c);
    drain("drain_noninv8");

    // Illegal operands
    issue8(8'd0,  8'd0, 8'd0,  8'd0, 1'b0, 1'b1, 1'b1, c);
    drain("drain_err_base0");
    issue8(8'd13, 8'd2, 8'd13, 8'd0, 1'b0, 1'b1, 1'b1, c);
    drain("drain_err_a_eq_base");
    issue8(8'd0,  8'd0, 8'd1,  8'd0, 1'b0, 1'b1, 1'b1, c);
    drain("drain_err_base1");
    issue8(8'd3,  8'd13, 8'd13, 8'd0, 1'b0, 1'b1, 1'b1, c);
    drain("drain_err_b_eq_base");

    // Ignored starts mid-ITER and during DONE
    issue8(8'd200, 8'd150, 8'd251, 8'd131, 1'b0, 1'b0, 1'b1, c);
    wait_cyc(c + 4);
    a8 = 8'd1; b8 = 8'd1; m8 = 8'd13; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    wait_cyc(c + 10);
    chk("busy_in_done8", 512'(bz8), 512'(1));
    a8 = 8'd5; b8 = 8'd8; m8 = 8'd13; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    chk("busy_fall8", 512'(bz8), 512'(0));
    repeat (15) @(negedge clk);
    chk("no_second_job8", 512'(bz8), 512'(0));
    drain("drain_ignored8");

    // Reset during ITER (four bits processed), no expectation pushed
    issue8(8'd5, 8'd8, 8'd13, 8'd1, 1'b1, 1'b0, 1'b0, c);
    wait_cyc(c + 6);
    rst_n = 1'b0;
    #1;
    chk("abort_prod8",  512'(p8),  '0);
    chk("abort_match8", 512'(mt8), '0);
    chk("abort_valid8", 512'(vo8), '0);
    chk("abort_busy8",  512'(bz8), '0);
    chk("abort_err8",   512'(er8), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(8'd5, 8'd8, 8'd13, 8'd1, 1'b1, 1'b0, 1'b1, c);
    drain("drain_after_reset8");

    // 512-bit inverse check
    a_raw = 512'd11771277631567105112429390968344039472017655878094069789596899075379556637591777263612685912638072676971202571005125788549738055042212111622006381650085741;
    b_raw = 512'd3026486573922135933347162266434197347000801954591955628451452122615628358378622438321873052256261617382380550515818316432815442076960637096436427767588780;
    m_raw = 512'd7038747235645766647601534062230126447880082574479551592729267315028956456991270137047483167243727743721697091099593982762286861266825761539834903570699207;
    @(negedge clk);
    a512 = a_raw % m_raw;
    b512 = b_raw;
    m512 = m_raw;
    v512 = 1'b1;
    c = cyc;
    e.prod  = 512'd1;
    e.match = 1'b1;
    e.err   = 1'b0;
    e.due   = c + 514;
    q512.push_back(e);
    @(negedge clk);
    v512 = 1'b0;
    a512 = '0; b512 = '0; m512 = '0;
    chk("busy512", 512'(bz512), 512'(1));
    drain("drain_512");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
